// File: rtl/branch_pc_unit.sv
// Program counter plus decode-stage branch/jump resolver with a one-slot redirect FSM
// and saturating branch/taken statistics counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Valid_ID,
  input  logic [2:0]       BranchJump,
  input  logic [4:0]       RegimmRt,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  input  logic [15:0]      Imm16,
  input  logic [25:0]      Target26,
  input  logic [31:0]      PCPlus4_ID,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Taken,
  output logic             Flush,
  output logic             IllegalBJ,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount,
  output logic             fsm_state
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  localparam logic [2:0] BJ_NONE   = 3'b000;
  localparam logic [2:0] BJ_BEQ    = 3'b001;
  localparam logic [2:0] BJ_BNE    = 3'b010;
  localparam logic [2:0] BJ_JUMP   = 3'b011;
  localparam logic [2:0] BJ_REGIMM = 3'b100;
  localparam logic [2:0] BJ_BGTZ   = 3'b101;
  localparam logic [2:0] BJ_BLEZ   = 3'b110;
  localparam logic [2:0] BJ_RSVD   = 3'b111;

  logic [0:0]  state;
  logic        id_live;
  logic        resolve;
  logic        cond;
  logic        count_en;
  logic        rs_neg;
  logic        rs_zero;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;

  assign fsm_state = state;

  // The ID slot is only looked at in RUN; in REDIRECT it holds the squashed fetch.
  assign id_live = Valid_ID & ~Stall & ~Rst & (state == S_RUN);
  assign resolve = id_live & (BranchJump != BJ_NONE);

  assign rs_neg  = RsData[31];
  assign rs_zero = (RsData == 32'd0);

  always_comb begin
    cond = 1'b0;
    case (BranchJump)
      BJ_BEQ:    cond = (RsData == RtData);
      BJ_BNE:    cond = (RsData != RtData);
      BJ_JUMP:   cond = 1'b1;
      BJ_REGIMM: cond = RegimmRt[0] ? ~rs_neg : rs_neg;
      BJ_BGTZ:   cond = ~rs_neg & ~rs_zero;
      BJ_BLEZ:   cond = rs_neg | rs_zero;
      default:   cond = 1'b0;
    endcase
  end

  assign Taken     = resolve & cond;
  assign Flush     = Taken;
  assign IllegalBJ = id_live & (BranchJump == BJ_RSVD);
  assign count_en  = resolve & (BranchJump != BJ_RSVD);

  assign branch_off    = {{14{Imm16[15]}}, Imm16, 2'b00};
  assign branch_target = PCPlus4_ID + branch_off;
  assign jump_target   = {PCPlus4_ID[31:28], Target26, 2'b00};
  assign target        = (BranchJump == BJ_JUMP) ? jump_target : branch_target;

  assign PCPlus4 = PC + 32'd4;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC          <= RESET_PC;
      state       <= S_RUN;
      BranchCount <= '0;
      TakenCount  <= '0;
    end else if (!Stall) begin
      PC <= Taken ? target : PCPlus4;
      case (state)
        S_RUN:      state <= Taken ? S_REDIRECT : S_RUN;
        S_REDIRECT: state <= S_RUN;
        default:    state <= S_RUN;
      endcase
      // Saturate at all-ones rather than wrapping.
      if (count_en && (BranchCount != {CNT_W{1'b1}}))
        BranchCount <= BranchCount + 1'b1;
      if (Taken && (TakenCount != {CNT_W{1'b1}}))
        TakenCount <= TakenCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: two instances (16-bit and 2-bit counters) share one stimulus
// stream and are checked each cycle against a behavioural model of the next-PC rules.
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, valid;
  logic [2:0]  code;
  logic [4:0]  regimm_rt;
  logic [31:0] rs_data, rt_data, pcp4;
  logic [15:0] imm;
  logic [25:0] t26;

  logic [31:0] pc_a, pcp4_a, pc_b, pcp4_b;
  logic        taken_a, flush_a, ill_a, st_a, taken_b, flush_b, ill_b, st_b;
  logic [15:0] bc_a, tc_a;
  logic [1:0]  bc_b, tc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_redirect;
  int          m_bc, m_tc;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(RST_PC), .CNT_W(16)) dut_a (
    .Clk(clk), .Rst(rst), .Stall(stall), .Valid_ID(valid), .BranchJump(code),
    .RegimmRt(regimm_rt), .RsData(rs_data), .RtData(rt_data), .Imm16(imm),
    .Target26(t26), .PCPlus4_ID(pcp4), .PC(pc_a), .PCPlus4(pcp4_a),
    .Taken(taken_a), .Flush(flush_a), .IllegalBJ(ill_a), .BranchCount(bc_a),
    .TakenCount(tc_a), .fsm_state(st_a));

  branch_pc_unit #(.RESET_PC(RST_PC), .CNT_W(2)) dut_b (
    .Clk(clk), .Rst(rst), .Stall(stall), .Valid_ID(valid), .BranchJump(code),
    .RegimmRt(regimm_rt), .RsData(rs_data), .RtData(rt_data), .Imm16(imm),
    .Target26(t26), .PCPlus4_ID(pcp4), .PC(pc_b), .PCPlus4(pcp4_b),
    .Taken(taken_b), .Flush(flush_b), .IllegalBJ(ill_b), .BranchCount(bc_b),
    .TakenCount(tc_b), .fsm_state(st_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int c, input int maxv);
    return (c > maxv) ? 32'(maxv) : 32'(c);
  endfunction

  task automatic set_id(input logic v, input logic [2:0] c, input logic [4:0] rt,
                        input logic [31:0] rs, input logic [31:0] rtd, input logic [15:0] im,
                        input logic [25:0] tg, input logic [31:0] p4);
    valid = v; code = c; regimm_rt = rt; rs_data = rs; rt_data = rtd;
    imm = im; t26 = tg; pcp4 = p4;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0);
  endtask

  // One clock: check combinational outputs before the edge, advance the model,
  // then check registered state just after the edge.
  task automatic cycle();
    logic act, cnd, e_taken, e_ill;
    logic [31:0] tgt;
    @(negedge clk);
    act = !rst && valid && !stall && !m_redirect;
    case (code)
      3'd1:    cnd = (rs_data == rt_data);
      3'd2:    cnd = (rs_data != rt_data);
      3'd3:    cnd = 1'b1;
      3'd4:    cnd = regimm_rt[0] ? ($signed(rs_data) >= 0) : ($signed(rs_data) < 0);
      3'd5:    cnd = ($signed(rs_data) > 0);
      3'd6:    cnd = ($signed(rs_data) <= 0);
      default: cnd = 1'b0;
    endcase
    e_taken = act && cnd;
    e_ill   = act && (code == 3'd7);
    if (code == 3'd3) tgt = {pcp4[31:28], t26, 2'b00};
    else              tgt = pcp4 + 32'(int'($signed(imm)) * 4);
    chk("taken_a", 32'(taken_a), 32'(e_taken));
    chk("flush_a", 32'(flush_a), 32'(e_taken));
    chk("illegal_a", 32'(ill_a), 32'(e_ill));
    chk("taken_b", 32'(taken_b), 32'(e_taken));
    chk("pcplus4", pcp4_a, m_pc + 32'd4);
    if (rst) begin
      m_pc = RST_PC; m_redirect = 1'b0; m_bc = 0; m_tc = 0;
    end else if (!stall) begin
      if (act && code != 3'd0 && code != 3'd7) m_bc++;
      if (e_taken) m_tc++;
      m_pc = e_taken ? tgt : m_pc + 32'd4;
      m_redirect = e_taken;
    end
    @(posedge clk);
    #1;
    chk("pc_a", pc_a, m_pc);
    chk("pc_b", pc_b, m_pc);
    chk("state_a", 32'(st_a), 32'(m_redirect));
    chk("bcount_a", 32'(bc_a), sat(m_bc, 65535));
    chk("tcount_a", 32'(tc_a), sat(m_tc, 65535));
    chk("bcount_b", 32'(bc_b), sat(m_bc, 3));
    chk("tcount_b", 32'(tc_b), sat(m_tc, 3));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    m_pc = RST_PC; m_redirect = 1'b0; m_bc = 0; m_tc = 0;
    cycle();
    chk("reset_pc", pc_a, 32'h100);
    rst = 1'b0;
    repeat (3) cycle();
    chk("seq_pc", pc_a, 32'h10C);
    chk("seq_bc", 32'(bc_a), 32'd0);

    // beq taken, then the squashed slot ignores an identical valid beq
    set_id(1'b1, 3'd1, 5'd0, 32'd5, 32'd5, 16'hFFFE, 26'd0, 32'h204);
    cycle();
    chk("beq_pc", pc_a, 32'h1FC);
    chk("beq_tc", 32'(tc_a), 32'd1);
    cycle();
    chk("squash_bc", 32'(bc_a), 32'd1);

    set_id(1'b1, 3'd2, 5'd0, 32'd7, 32'd7, 16'h0010, 26'd0, 32'h300);
    cycle();
    chk("bne_tc", 32'(tc_a), 32'd1);
    set_id(1'b1, 3'd4, 5'd0, 32'h8000_0000, 32'd0, 16'h0004, 26'd0, 32'h400);
    cycle();
    chk("bltz_pc", pc_a, 32'h410);
    idle(); cycle();

    set_id(1'b1, 3'd3, 5'd0, 32'd0, 32'd0, 16'd0, 26'h0000040, 32'h9000_0010);
    cycle();
    chk("jump_pc", pc_a, 32'h9000_0100);
    idle(); cycle();
    set_id(1'b1, 3'd6, 5'd0, 32'd0, 32'd0, 16'h0001, 26'd0, 32'h500);
    cycle();
    idle(); cycle();
    set_id(1'b1, 3'd5, 5'd0, 32'd0, 32'd0, 16'h0001, 26'd0, 32'h600);
    cycle();

    // stalled beq held for two cycles, resolved once when released
    set_id(1'b1, 3'd1, 5'd0, 32'd9, 32'd9, 16'h0020, 26'd0, 32'h700);
    stall = 1'b1; cycle(); cycle();
    stall = 1'b0; cycle();
    chk("stall_pc", pc_a, 32'h780);
    chk("sat_tc_b", 32'(tc_b), 32'd3);
    idle(); cycle();

    set_id(1'b1, 3'd7, 5'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0);
    cycle();
    stall = 1'b1; cycle(); stall = 1'b0;

    // reset while in REDIRECT
    set_id(1'b1, 3'd3, 5'd0, 32'd0, 32'd0, 16'd0, 26'h0000100, 32'h0000_0800);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_redir_pc", pc_a, 32'h100);

    // stall while in REDIRECT keeps the slot squashed
    set_id(1'b1, 3'd1, 5'd0, 32'd1, 32'd1, 16'h0008, 26'd0, 32'h0000_0900);
    cycle();
    stall = 1'b1; cycle(); stall = 1'b0; cycle(); cycle();

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      valid = ($urandom_range(0, 4) != 0);
      code  = 3'($urandom_range(0, 7));
      regimm_rt = 5'($urandom);
      case ($urandom_range(0, 3))
        0: rs_data = 32'd0;
        1: rs_data = 32'h8000_0000;
        2: rs_data = 32'($urandom_range(0, 3)) - 32'd1;
        default: rs_data = $urandom;
      endcase
      rt_data = ($urandom_range(0, 1) == 0) ? rs_data : $urandom;
      imm  = 16'($urandom);
      t26  = 26'($urandom);
      pcp4 = {$urandom, 2'b00} >> 2 << 2;
      if ($urandom_range(0, 9) == 0) pcp4 = 32'hFFFF_FFFC;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
